// File: rtl/freq_div_monitor_if.sv
// Bundle between a divided-clock source and the freq_div_monitor checker.
// master drives div_clk and observes status; slave is the monitor.
interface freq_div_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
);
  logic             div_clk;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output div_clk,
    input  period, high_time, meas_valid,
    input  locked, err, err_cnt
  );

  modport slave (
    input  div_clk,
    output period, high_time, meas_valid,
    output locked, err, err_cnt
  );
endinterface

// File: rtl/freq_div_monitor.sv
// Measures period/high time of div_clk in clk_in cycles, reports lock and errors.
// Define FREQ_DIV_MONITOR_SYNC_EN to pass div_clk through a 2-flop synchroniser.
module freq_div_monitor #(
  parameter int N        = 2,
  parameter int EXP_HIGH = N/2,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 4*N,
  parameter int ERR_W    = 8
) (
  input logic clk_in,
  input logic reset,
  freq_div_monitor_if.slave bus
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] N_C  = CNT_W'(N);
  localparam logic [CNT_W-1:0] EH_C = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LK_C = GW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t           state, state_n;
  logic             div_s, div_q, rise;
  logic [CNT_W-1:0] pcnt, hcnt;
  logic [CNT_W-1:0] period_r, period_n;
  logic [CNT_W-1:0] high_r, high_n;
  logic [GW-1:0]    good_cnt, good_n;
  logic [ERR_W-1:0] ecnt_r, ecnt_n;
  logic             mv_r, mv_n;
  logic             err_r, err_n;
  logic             lock_r, lock_n;
  logic             good, tout;

`ifdef FREQ_DIV_MONITOR_SYNC_EN
  logic [1:0] sync_r;

  // two-flop synchroniser for an asynchronous div_clk
  always_ff @(posedge clk_in) begin
    if (reset) sync_r <= '0;
    else       sync_r <= {sync_r[0], bus.div_clk};
  end

  assign div_s = sync_r[1];
`else
  assign div_s = bus.div_clk;
`endif

  assign rise = div_s & ~div_q;
  assign good = (pcnt == N_C) && (hcnt == EH_C);
  assign tout = (pcnt == TO_C);

  // edge history and free-running saturating period/high counters
  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_q <= 1'b0;
      pcnt  <= '0;
      hcnt  <= '0;
    end else begin
      div_q <= div_s;
      if (rise) begin
        pcnt <= CNT_W'(1);
        hcnt <= CNT_W'(1);
      end else begin
        if (pcnt != CMAX) pcnt <= pcnt + 1'b1;
        if (div_s && hcnt != CMAX) hcnt <= hcnt + 1'b1;
      end
    end
  end

  // next state, measurement capture and status decisions
  always_comb begin
    state_n  = state;
    good_n   = good_cnt;
    period_n = period_r;
    high_n   = high_r;
    lock_n   = lock_r;
    mv_n     = 1'b0;
    err_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = MEASURE;
          good_n  = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_n = pcnt;
          high_n   = hcnt;
          mv_n     = 1'b1;
          if (good) begin
            good_n = good_cnt + 1'b1;
            if (good_cnt == LK_C) begin
              lock_n  = 1'b1;
              state_n = LOCKED;
            end
          end else begin
            err_n  = 1'b1;
            good_n = '0;
          end
        end else if (tout) begin
          err_n   = 1'b1;
          lock_n  = 1'b0;
          state_n = IDLE;
        end
      end
      LOCKED: begin
        if (rise) begin
          period_n = pcnt;
          high_n   = hcnt;
          mv_n     = 1'b1;
          if (!good) begin
            err_n   = 1'b1;
            lock_n  = 1'b0;
            good_n  = '0;
            state_n = MEASURE;
          end
        end else if (tout) begin
          err_n   = 1'b1;
          lock_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    ecnt_n = ecnt_r;
    if (err_n && ecnt_r != '1) ecnt_n = ecnt_r + 1'b1;
  end

  // state and registered outputs
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= IDLE;
      good_cnt <= '0;
      period_r <= '0;
      high_r   <= '0;
      lock_r   <= 1'b0;
      mv_r     <= 1'b0;
      err_r    <= 1'b0;
      ecnt_r   <= '0;
    end else begin
      state    <= state_n;
      good_cnt <= good_n;
      period_r <= period_n;
      high_r   <= high_n;
      lock_r   <= lock_n;
      mv_r     <= mv_n;
      err_r    <= err_n;
      ecnt_r   <= ecnt_n;
    end
  end

  assign bus.period     = period_r;
  assign bus.high_time  = high_r;
  assign bus.meas_valid = mv_r;
  assign bus.locked     = lock_r;
  assign bus.err        = err_r;
  assign bus.err_cnt    = ecnt_r;

endmodule

// File: tb/tb_freq_div_monitor.sv
// Randomised bench for freq_div_monitor (N=4, ERR_W=2) against a
// period-level reference model built from rise timestamps.
module tb_freq_div_monitor;

  localparam int NN   = 4;
  localparam int EH   = 2;
  localparam int TO   = 16;
  localparam int LK   = 4;
  localparam int EMAX = 3;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  freq_div_monitor_if #(.CNT_W(8), .ERR_W(2)) bus();

  freq_div_monitor #(
    .N(NN), .EXP_HIGH(EH), .CNT_W(8),
    .LOCK_CNT(LK), .TIMEOUT(TO), .ERR_W(2)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  int hist[$];
  int st;
  int gc;
  int t_rise;
  int prev;
  int d1, d2;
  int e_mv, e_err, e_lock, e_ecnt, e_per, e_hi;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    chk("meas_valid", 32'(bus.meas_valid), 32'(e_mv));
    chk("err",        32'(bus.err),        32'(e_err));
    chk("locked",     32'(bus.locked),     32'(e_lock));
    chk("err_cnt",    32'(bus.err_cnt),    32'(e_ecnt));
    chk("period",     32'(bus.period),     32'(e_per));
    chk("high_time",  32'(bus.high_time),  32'(e_hi));
  endtask

  task automatic model_reset();
    hist.delete();
    st = 0; gc = 0; t_rise = 0; prev = 0;
    d1 = 0; d2 = 0;
    e_mv = 0; e_err = 0; e_lock = 0;
    e_ecnt = 0; e_per = 0; e_hi = 0;
  endtask

  task automatic model_step(input int v);
    int s, t, per, hi;
    s = v;
`ifdef FREQ_DIV_MONITOR_SYNC_EN
    s = d2; d2 = d1; d1 = v;
`endif
    t = hist.size();
    e_mv = 0;
    e_err = 0;
    if (s == 1 && prev == 0) begin
      if (st != 0) begin
        per = t - t_rise;
        hi = 0;
        for (int i = t_rise; i < t; i++) hi += hist[i];
        e_per = (per > 255) ? 255 : per;
        e_hi  = (hi > 255) ? 255 : hi;
        e_mv  = 1;
        if (per == NN && hi == EH) begin
          if (st == 1) begin
            gc++;
            if (gc == LK) begin e_lock = 1; st = 2; end
          end
        end else begin
          e_err = 1;
          gc = 0;
          if (st == 2) begin e_lock = 0; st = 1; end
        end
      end else begin
        st = 1;
        gc = 0;
      end
      t_rise = t;
    end else if (st != 0 && t - t_rise == TO) begin
      e_err = 1;
      e_lock = 0;
      st = 0;
    end
    if (e_err == 1 && e_ecnt < EMAX) e_ecnt++;
    hist.push_back(s);
    prev = s;
  endtask

  task automatic step(input int v);
    @(negedge clk_in);
    bus.div_clk = v[0];
    @(posedge clk_in);
    #1;
    model_step(v);
    compare();
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk_in);
    reset = 1'b1;
    bus.div_clk = 1'($urandom_range(0, 1));
    repeat (cyc) begin
      @(posedge clk_in);
      #1;
      model_reset();
      compare();
    end
    reset = 1'b0;
  endtask

  task automatic per(input int h, input int l);
    repeat (h) step(1);
    repeat (l) step(0);
  endtask

  initial begin
    int r;
    bus.div_clk = 1'b0;
    model_reset();
    do_reset(2);

    repeat (8) per(2, 2);
    repeat (20) step(0);

    repeat (6) per(2, 2);
    per(2, 3);
    repeat (5) per(2, 2);

    repeat (6) per(3, 1);

    do_reset(1);
    repeat (6) per(2, 2);
    do_reset(2);
    repeat (2) per(2, 2);

    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)
        per(2, 2);
      else if (r < 88)
        per(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
      else if (r < 97)
        per(1, int'($urandom_range(13, 20)));
      else
        do_reset(int'($urandom_range(1, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
